// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard unit.
// Stage records carry only what stall and forwarding decisions need.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int TW     = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TW-1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic              we;
        logic [TW-1:0]     tnew;
    } rec_t;

    localparam rec_t REC_NONE = '0;

    function automatic logic live(input rec_t x);
        return x.we && (x.a3 != '0);
    endfunction

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Priority encoder picking the youngest stage that can forward register r.
// Unused candidate slots are tied to an empty record.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] r,
    input  rec_t              e,
    input  rec_t              m,
    input  rec_t              w,
    output logic [1:0]        sel
);

    function automatic logic cand(input rec_t x, input logic [REG_AW-1:0] reg_a);
        return live(x) && (x.a3 == reg_a) && (x.tnew == '0);
    endfunction

    always_comb begin
        sel = FWD_GRF;
        if (r != '0) begin
            if (cand(e, r))
                sel = FWD_E;
            else if (cand(m, r))
                sel = FWD_M;
            else if (cand(w, r))
                sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding control for the 5-stage MIPS pipeline.
// Shadow records of E/M/W advance with the pipeline; a stall bubbles E.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA_W = 5,
    parameter int T_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] d_rs,
    input  logic [RA_W-1:0] d_rt,
    input  logic            d_rs_used,
    input  logic            d_rt_used,
    input  logic [T_W-1:0]  d_rs_tuse,
    input  logic [T_W-1:0]  d_rt_tuse,
    input  logic [RA_W-1:0] d_a3,
    input  logic            d_regwrite,
    input  logic [T_W-1:0]  d_tnew,
    output logic            stall,
    output logic [1:0]      fwd_rs_d,
    output logic [1:0]      fwd_rt_d,
    output logic [1:0]      fwd_rs_e,
    output logic [1:0]      fwd_rt_e,
    output logic [1:0]      fwd_rt_m
);

    rec_t              e_rec;
    rec_t              m_rec;
    rec_t              w_rec;
    logic [REG_AW-1:0] e_rs;
    logic [REG_AW-1:0] e_rt;
    logic [REG_AW-1:0] m_rt;

    logic stall_rs;
    logic stall_rt;

    // A producer blocks D when its result arrives later than D needs it.
    function automatic logic late(input rec_t x,
                                  input logic [REG_AW-1:0] r,
                                  input logic [TW-1:0] tuse);
        return live(x) && (x.a3 == r) && (x.tnew > tuse);
    endfunction

    always_comb begin
        stall_rs = d_rs_used && (d_rs != '0) &&
                   (late(e_rec, d_rs, d_rs_tuse) ||
                    late(m_rec, d_rs, d_rs_tuse));
        stall_rt = d_rt_used && (d_rt != '0) &&
                   (late(e_rec, d_rt, d_rt_tuse) ||
                    late(m_rec, d_rt, d_rt_tuse));
        stall    = stall_rs || stall_rt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rec <= REC_NONE;
            m_rec <= REC_NONE;
            w_rec <= REC_NONE;
            e_rs  <= '0;
            e_rt  <= '0;
            m_rt  <= '0;
        end else begin
            if (stall) begin
                e_rec <= REC_NONE;
                e_rs  <= '0;
                e_rt  <= '0;
            end else begin
                e_rec <= '{a3: d_a3, we: d_regwrite, tnew: d_tnew};
                e_rs  <= d_rs_used ? d_rs : '0;
                e_rt  <= d_rt_used ? d_rt : '0;
            end
            m_rec <= '{a3: e_rec.a3, we: e_rec.we, tnew: tnew_dec(e_rec.tnew)};
            m_rt  <= e_rt;
            w_rec <= '{a3: m_rec.a3, we: m_rec.we, tnew: '0};
        end
    end

    fwd_select u_rs_d (
        .r   (d_rs),
        .e   (e_rec),
        .m   (m_rec),
        .w   (w_rec),
        .sel (fwd_rs_d)
    );

    fwd_select u_rt_d (
        .r   (d_rt),
        .e   (e_rec),
        .m   (m_rec),
        .w   (w_rec),
        .sel (fwd_rt_d)
    );

    fwd_select u_rs_e (
        .r   (e_rs),
        .e   (REC_NONE),
        .m   (m_rec),
        .w   (w_rec),
        .sel (fwd_rs_e)
    );

    fwd_select u_rt_e (
        .r   (e_rt),
        .e   (REC_NONE),
        .m   (m_rec),
        .w   (w_rec),
        .sel (fwd_rt_e)
    );

    fwd_select u_rt_m (
        .r   (m_rt),
        .e   (REC_NONE),
        .m   (REC_NONE),
        .w   (w_rec),
        .sel (fwd_rt_m)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit: table of per-cycle D inputs with
// hand-derived stall/forward expectations, plus multi-cycle stall and reset cases.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_rs_used;
    logic       d_rt_used;
    logic [1:0] d_rs_tuse;
    logic [1:0] d_rt_tuse;
    logic [4:0] d_a3;
    logic       d_regwrite;
    logic [1:0] d_tnew;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic [1:0] fwd_rt_m;

    int applied = 0;
    int miscompares = 0;

    hazard_unit #(.RA_W(5), .T_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_used  (d_rs_used),
        .d_rt_used  (d_rt_used),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .d_tnew     (d_tnew),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e),
        .fwd_rt_m   (fwd_rt_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       rsu, rtu;
        logic [1:0] rst, rtt;
        logic [4:0] a3;
        logic       we;
        logic [1:0] tn;
        logic       st;
        logic [1:0] frd, ftd, fre, fte, ftm;
    } vec_t;

    function automatic vec_t mk(
        input int rs, input int rt, input int rsu, input int rtu,
        input int rst, input int rtt, input int a3, input int we,
        input int tn, input int st, input int frd, input int ftd,
        input int fre, input int fte, input int ftm);
        vec_t v;
        v.rs = 5'(rs);  v.rt = 5'(rt);
        v.rsu = 1'(rsu); v.rtu = 1'(rtu);
        v.rst = 2'(rst); v.rtt = 2'(rtt);
        v.a3 = 5'(a3);  v.we = 1'(we); v.tn = 2'(tn);
        v.st = 1'(st);
        v.frd = 2'(frd); v.ftd = 2'(ftd);
        v.fre = 2'(fre); v.fte = 2'(fte); v.ftm = 2'(ftm);
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        applied++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_rt = v.rt;
        d_rs_used = v.rsu; d_rt_used = v.rtu;
        d_rs_tuse = v.rst; d_rt_tuse = v.rtt;
        d_a3 = v.a3; d_regwrite = v.we; d_tnew = v.tn;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " stall"},    int'(stall),    int'(v.st));
        chk({tag, " fwd_rs_d"}, int'(fwd_rs_d), int'(v.frd));
        chk({tag, " fwd_rt_d"}, int'(fwd_rt_d), int'(v.ftd));
        chk({tag, " fwd_rs_e"}, int'(fwd_rs_e), int'(v.fre));
        chk({tag, " fwd_rt_e"}, int'(fwd_rt_e), int'(v.fte));
        chk({tag, " fwd_rt_m"}, int'(fwd_rt_m), int'(v.ftm));
    endtask

    vec_t tbl[17];
    vec_t nop;
    vec_t lw8;
    vec_t beq8;
    vec_t add9;
    vec_t zero_exp;

    initial begin
        // rs rt rsu rtu rst rtt a3 we tn | st frd ftd fre fte ftm
        tbl[0]  = mk(1, 0, 1, 0, 1, 0, 8, 1, 2,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(8, 1, 1, 1, 1, 1, 9, 1, 1,  1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(8, 1, 1, 1, 1, 1, 9, 1, 1,  0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(2, 3, 1, 1, 1, 1, 8, 1, 1,  0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(8, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(8, 0, 1, 1, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0, 3, 0, 0);
        tbl[9]  = mk(31, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 1, 0, 1, 0, 0, 1, 1,  0, 0, 0, 2, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 1, 1, 2, 1, 1,  0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 1, 1, 1, 5, 1, 1,  0, 0, 0, 0, 0, 0);
        tbl[13] = mk(2, 3, 1, 1, 1, 1, 5, 1, 1,  0, 2, 0, 0, 0, 0);
        tbl[14] = mk(1, 5, 1, 1, 1, 2, 0, 0, 0,  0, 0, 2, 3, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);

        nop      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero_exp = nop;
        lw8      = mk(1, 0, 1, 0, 1, 0, 8, 1, int'(TNEW_LOAD), 0, 0, 0, 0, 0, 0);
        beq8     = mk(8, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add9     = mk(8, 1, 1, 1, 1, 1, 9, 1, int'(TNEW_ALU), 1, 0, 0, 0, 0, 0);

        reset = 1'b0;
        drive(nop);
        #1;
        check_all("reset", zero_exp);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_all($sformatf("v%0d", i), tbl[i]);
            @(posedge clk); #1;
        end

        // lw then beq on its result: two bubbles, then forward from W
        drive(lw8);
        @(posedge clk); #1;
        drive(beq8);
        @(negedge clk);
        chk("ldbeq c1 stall", int'(stall), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ldbeq c2 stall", int'(stall), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ldbeq c3 stall", int'(stall), 0);
        chk("ldbeq c3 fwd_rs_d", int'(fwd_rs_d), int'(FWD_W));
        @(posedge clk); #1;
        drive(nop);
        repeat (3) begin
            @(posedge clk); #1;
        end

        // reset asserted in the middle of a load-use stall
        drive(lw8);
        @(posedge clk); #1;
        drive(add9);
        @(negedge clk);
        chk("rststall pre stall", int'(stall), 1);
        #1;
        reset = 1'b0;
        #1;
        check_all("rststall async", zero_exp);
        @(posedge clk); #1;
        check_all("rststall held", zero_exp);
        reset = 1'b1;
        drive(nop);
        @(negedge clk);
        check_all("rststall release", zero_exp);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
